// File: rtl/writeback_port_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_port_arbiter
//
// Shares the single register-file write port between two requesters:
//   requester 0 - the in-order pipeline W stage (pipe_*), never buffered
//   requester 1 - the long-latency load-return path (ret_*), buffered in a
//                 small FIFO so returns can wait while the pipeline writes
//
// The pipeline normally wins. The FIFO head is force-granted when it has
// been passed over STARVE_LIMIT times in a row, or when the pipe write
// targets a register that a buffered return also targets (write-after-write
// hazard). In the hazard case the buffered returns drain first, so the
// younger pipe write lands last.
//
// The regfile drive outputs are registered: one cycle after a grant the
// winning address/data appear on write_address_W/data_bus_W with the
// matching scalar or vector enable.
//
// Ports
//   clock               in   rising-edge clock
//   async_reset         in   asynchronous active-high reset
//   pipe_valid          in   W stage has a write this cycle
//   pipe_addr           in   W stage destination (bit 5 = vector file)
//   pipe_data           in   W stage data
//   pipe_ready          out  W write accepted this cycle (0 = hold W)
//   ret_valid           in   return path offers a write
//   ret_addr            in   return destination
//   ret_data            in   return data
//   ret_ready           out  FIFO can accept a return (= not full)
//   write_address_W     out  registered regfile write address
//   data_bus_W          out  registered regfile write data
//   write_scalar_reg_W  out  registered scalar write enable (x0 suppressed)
//   write_vector_reg_W  out  registered vector write enable
//   fifo_count          out  current FIFO occupancy
// -----------------------------------------------------------------------------
module writeback_port_arbiter #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int PTR_W       = $clog2(FIFO_DEPTH),
  localparam int CNT_W       = PTR_W + 1,
  localparam int STV_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clock,
  input  logic              async_reset,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_ready,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [DATA_W-1:0] ret_data,
  output logic              ret_ready,
  output logic [ADDR_W-1:0] write_address_W,
  output logic [DATA_W-1:0] data_bus_W,
  output logic              write_scalar_reg_W,
  output logic              write_vector_reg_W,
  output logic [CNT_W-1:0]  fifo_count
);

  // Address bit that selects the vector register file.
  localparam int VEC_BIT = 5;

  // Decode of a granted address into the scalar enable: scalar file and not x0.
  function automatic logic scalar_write_en(input logic [ADDR_W-1:0] addr);
    scalar_write_en = (addr[VEC_BIT] == 1'b0) && (addr[VEC_BIT-1:0] != 5'd0);
  endfunction

  // Decode of a granted address into the vector enable.
  function automatic logic vector_write_en(input logic [ADDR_W-1:0] addr);
    vector_write_en = addr[VEC_BIT];
  endfunction

  // ---------------------------------------------------------------------------
  // Requester-1 buffer state
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]     fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_valid_r;   // per-slot occupancy, used for the hazard search
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [STV_W-1:0]      starve_r;

  // ---------------------------------------------------------------------------
  // Combinational arbitration signals
  // ---------------------------------------------------------------------------
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [FIFO_DEPTH-1:0] addr_match_s;
  logic                  waw_hit_s;
  logic                  starve_limit_s;
  logic                  force_s;
  logic                  grant_pipe_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  grant_any_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_data_s;

  // Per-slot address compare against the pipe destination.
  always_comb begin
    addr_match_s = {FIFO_DEPTH{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      addr_match_s[i] = fifo_valid_r[i] && (fifo_addr_r[i] == pipe_addr);
    end
  end

  // Grant decision: pipe wins unless the FIFO head is forced.
  always_comb begin
    fifo_empty_s   = (count_r == {CNT_W{1'b0}});
    fifo_full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    waw_hit_s      = pipe_valid && (|addr_match_s);
    starve_limit_s = (starve_r >= STV_W'(STARVE_LIMIT));
    force_s        = !fifo_empty_s && (starve_limit_s || waw_hit_s);
    grant_pipe_s   = pipe_valid && !force_s;
    // A push landing this cycle is not visible here: only already-held
    // entries are eligible, so a push into an empty FIFO waits a cycle.
    pop_s          = !grant_pipe_s && !fifo_empty_s;
    // Acceptance depends only on full, never on a same-cycle pop.
    push_s         = ret_valid && !fifo_full_s;
    grant_any_s    = grant_pipe_s || pop_s;
    if (grant_pipe_s) begin
      sel_addr_s = pipe_addr;
      sel_data_s = pipe_data;
    end else begin
      sel_addr_s = fifo_addr_r[rd_ptr_r];
      sel_data_s = fifo_data_r[rd_ptr_r];
    end
  end

  // Handshake outputs; pipe_ready ignores ret_valid so the W stage never
  // sees a same-cycle dependency on the return path.
  always_comb begin
    pipe_ready = !force_s || !pipe_valid;
    ret_ready  = !fifo_full_s;
    fifo_count = count_r;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // FIFO storage and per-slot valid bits; reset discards all buffered entries.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
      fifo_valid_r <= {FIFO_DEPTH{1'b0}};
    end else begin
      // Pop and push never touch the same slot in one cycle: a push needs a
      // non-full FIFO, so the write slot differs from the occupied head.
      if (pop_s) begin
        fifo_valid_r[rd_ptr_r] <= 1'b0;
      end else begin
        fifo_valid_r[rd_ptr_r] <= fifo_valid_r[rd_ptr_r];
      end
      if (push_s) begin
        fifo_addr_r[wr_ptr_r]  <= ret_addr;
        fifo_data_r[wr_ptr_r]  <= ret_data;
        fifo_valid_r[wr_ptr_r] <= 1'b1;
      end else begin
        fifo_addr_r[wr_ptr_r]  <= fifo_addr_r[wr_ptr_r];
        fifo_data_r[wr_ptr_r]  <= fifo_data_r[wr_ptr_r];
      end
    end
  end

  // FIFO pointers (wrap naturally: depth is a power of two) and occupancy.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts pipe wins over a waiting head, saturating.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      starve_r <= {STV_W{1'b0}};
    end else if (pop_s || fifo_empty_s) begin
      starve_r <= {STV_W{1'b0}};
    end else if (grant_pipe_s && !starve_limit_s) begin
      starve_r <= starve_r + STV_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Registered regfile drive: address/data follow the winner and hold when idle.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      write_address_W    <= {ADDR_W{1'b0}};
      data_bus_W         <= {DATA_W{1'b0}};
      write_scalar_reg_W <= 1'b0;
      write_vector_reg_W <= 1'b0;
    end else if (grant_any_s) begin
      write_address_W    <= sel_addr_s;
      data_bus_W         <= sel_data_s;
      write_scalar_reg_W <= scalar_write_en(sel_addr_s);
      write_vector_reg_W <= vector_write_en(sel_addr_s);
    end else begin
      write_address_W    <= write_address_W;
      data_bus_W         <= data_bus_W;
      write_scalar_reg_W <= 1'b0;
      write_vector_reg_W <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_port_arbiter
//
// Directed bench for writeback_port_arbiter. A small reference model of the
// return FIFO and the starvation counter predicts each cycle's grant; the
// expected registered write is pushed onto a scoreboard when the stimulus is
// driven and popped/compared one edge later. Directed constant checks cover
// the reset, x0-drop, starvation, hazard and full-FIFO behaviour.
// -----------------------------------------------------------------------------
module tb_writeback_port_arbiter;

  localparam int DATA_W       = 128;
  localparam int ADDR_W       = 6;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_W        = 3;

  logic              clock = 1'b0;
  logic              async_reset;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_ready;
  logic              ret_valid;
  logic [ADDR_W-1:0] ret_addr;
  logic [DATA_W-1:0] ret_data;
  logic              ret_ready;
  logic [ADDR_W-1:0] write_address_W;
  logic [DATA_W-1:0] data_bus_W;
  logic              write_scalar_reg_W;
  logic              write_vector_reg_W;
  logic [CNT_W-1:0]  fifo_count;

  writeback_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .async_reset(async_reset),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data), .ret_ready(ret_ready),
    .write_address_W(write_address_W), .data_bus_W(data_bus_W),
    .write_scalar_reg_W(write_scalar_reg_W), .write_vector_reg_W(write_vector_reg_W),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic              sc;
    logic              vc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  wr_t               sb_q[$];
  ent_t              mf_q[$];
  int                m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              last_pipe_ready;
  logic              last_ret_ready;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mf_q.delete();
    sb_q.delete();
    m_starve = 0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step(input string tag);
    int                sz;
    bit                empty, waw, frc, gp, pop, push;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    wr_t               w;
    ent_t              e;
    #1;
    sz    = mf_q.size();
    empty = (sz == 0);
    waw   = 1'b0;
    foreach (mf_q[i]) if (pipe_valid && (mf_q[i].addr == pipe_addr)) waw = 1'b1;
    frc  = !empty && ((m_starve >= STARVE_LIMIT) || waw);
    gp   = pipe_valid && !frc;
    pop  = !gp && !empty;
    push = ret_valid && (sz < FIFO_DEPTH);
    last_pipe_ready = pipe_ready;
    last_ret_ready  = ret_ready;
    check({tag, ":pipe_ready"}, DATA_W'(pipe_ready), DATA_W'(!frc || !pipe_valid));
    check({tag, ":ret_ready"},  DATA_W'(ret_ready),  DATA_W'(sz < FIFO_DEPTH));
    check({tag, ":fifo_count"}, DATA_W'(fifo_count), DATA_W'(sz));
    w.sc = 1'b0;
    w.vc = 1'b0;
    if (gp || pop) begin
      a = gp ? pipe_addr : mf_q[0].addr;
      d = gp ? pipe_data : mf_q[0].data;
      m_addr = a;
      m_data = d;
      w.vc = a[5];
      w.sc = !a[5] && (a[4:0] != 5'd0);
    end
    w.addr = m_addr;
    w.data = m_data;
    sb_q.push_back(w);
    if (pop) void'(mf_q.pop_front());
    if (push) begin
      e.addr = ret_addr;
      e.data = ret_data;
      mf_q.push_back(e);
    end
    if (pop || empty) m_starve = 0;
    else if (gp && (m_starve < STARVE_LIMIT)) m_starve++;
    @(posedge clock);
    #1;
    w = sb_q.pop_front();
    check({tag, ":scalar_en"}, DATA_W'(write_scalar_reg_W), DATA_W'(w.sc));
    check({tag, ":vector_en"}, DATA_W'(write_vector_reg_W), DATA_W'(w.vc));
    check({tag, ":address"},   DATA_W'(write_address_W),    DATA_W'(w.addr));
    check({tag, ":data"},      data_bus_W,                  w.data);
  endtask

  task automatic drive(input logic pv, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic rv, input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rd);
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    ret_valid  = rv; ret_addr  = ra; ret_data  = rd;
  endtask

  initial begin
    // Power-on reset
    drive(1'b0, 6'h00, 128'h0, 1'b0, 6'h00, 128'h0);
    async_reset = 1'b1;
    model_reset();
    #1;
    check("por:fifo_count", DATA_W'(fifo_count), DATA_W'(0));
    check("por:ret_ready",  DATA_W'(ret_ready),  DATA_W'(1));
    check("por:enables",    DATA_W'({write_scalar_reg_W, write_vector_reg_W}), DATA_W'(0));
    @(posedge clock);
    @(posedge clock);
    #1;
    async_reset = 1'b0;

    // 1: hold three returns behind a busy pipe, then reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'h01 + 6'(k), 128'(16'h1000 + k), 1'b1, 6'h28 + 6'(k), 128'(16'h2000 + k));
      step("t1_fill");
    end
    check("t1:held", DATA_W'(fifo_count), DATA_W'(3));
    drive(1'b0, 6'h00, 128'h0, 1'b0, 6'h00, 128'h0);
    #2;
    async_reset = 1'b1;
    #1;
    check("t1:fifo_count", DATA_W'(fifo_count), DATA_W'(0));
    check("t1:ret_ready",  DATA_W'(ret_ready),  DATA_W'(1));
    check("t1:enables",    DATA_W'({write_scalar_reg_W, write_vector_reg_W}), DATA_W'(0));
    check("t1:address",    DATA_W'(write_address_W), DATA_W'(0));
    model_reset();
    @(posedge clock);
    #1;
    async_reset = 1'b0;

    // 2: plain pipe write, FIFO empty
    drive(1'b1, 6'h05, 128'hDEAD, 1'b0, 6'h00, 128'h0);
    step("t2");
    check("t2:pipe_ready", DATA_W'(last_pipe_ready),    DATA_W'(1));
    check("t2:scalar_en",  DATA_W'(write_scalar_reg_W), DATA_W'(1));
    check("t2:address",    DATA_W'(write_address_W),    DATA_W'(5));
    check("t2:data",       DATA_W'(data_bus_W[31:0]),   DATA_W'(32'hDEAD));

    // 3: vector return with pipe idle (push, then pop)
    drive(1'b0, 6'h00, 128'h0, 1'b1, 6'h23, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF);
    step("t3_push");
    check("t3:no_write", DATA_W'({write_scalar_reg_W, write_vector_reg_W}), DATA_W'(0));
    drive(1'b0, 6'h00, 128'h0, 1'b0, 6'h00, 128'h0);
    step("t3_pop");
    check("t3:vector_en", DATA_W'(write_vector_reg_W), DATA_W'(1));
    check("t3:address",   DATA_W'(write_address_W),    DATA_W'(6'h23));

    // 4: starvation - pipe busy every cycle with one entry waiting
    drive(1'b0, 6'h00, 128'h0, 1'b1, 6'h31, 128'h3131);
    step("t4_push");
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 6'h02, 128'(100 + k), 1'b0, 6'h00, 128'h0);
      step("t4_run");
      check("t4:pipe_ready", DATA_W'(last_pipe_ready), DATA_W'(k < 8));
    end
    check("t4:popped_addr", DATA_W'(write_address_W), DATA_W'(6'h31));
    check("t4:fifo_count",  DATA_W'(fifo_count),      DATA_W'(0));
    step("t4_retry");
    check("t4:retry_data",  data_bus_W, 128'(108));

    // 5: write-after-write hazard drains buffered returns first
    drive(1'b1, 6'h0A, 128'hA, 1'b1, 6'h07, 128'h7001);
    step("t5_a");
    drive(1'b1, 6'h0B, 128'hB, 1'b1, 6'h07, 128'h7002);
    step("t5_b");
    drive(1'b1, 6'h07, 128'h7777, 1'b0, 6'h00, 128'h0);
    step("t5_c");
    check("t5:ready_c", DATA_W'(last_pipe_ready), DATA_W'(0));
    check("t5:ret1",    data_bus_W, 128'h7001);
    step("t5_d");
    check("t5:ready_d", DATA_W'(last_pipe_ready), DATA_W'(0));
    check("t5:ret2",    data_bus_W, 128'h7002);
    step("t5_e");
    check("t5:ready_e", DATA_W'(last_pipe_ready), DATA_W'(1));
    check("t5:pipe",    data_bus_W, 128'h7777);

    // 6: fill to full, reject a 5th return even in a pop cycle, x0 write
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 6'h0C, 128'(k), 1'b1, 6'h30 + 6'(k), 128'(16'h3000 + k));
      step("t6_fill");
    end
    check("t6:full_ready", DATA_W'(ret_ready), DATA_W'(0));
    drive(1'b1, 6'h0C, 128'h44, 1'b1, 6'h3F, 128'hFFFF);
    step("t6_reject");
    check("t6:count_full", DATA_W'(fifo_count), DATA_W'(4));
    drive(1'b0, 6'h00, 128'h0, 1'b1, 6'h3F, 128'hFFFF);
    step("t6_popcyc");
    check("t6:ready_pop",  DATA_W'(last_ret_ready), DATA_W'(0));
    check("t6:count_pop",  DATA_W'(fifo_count),     DATA_W'(3));
    check("t6:ready_after",DATA_W'(ret_ready),      DATA_W'(1));
    drive(1'b1, 6'h00, 128'h5A5A, 1'b0, 6'h00, 128'h0);
    step("t6_x0");
    check("t6:x0_enables", DATA_W'({write_scalar_reg_W, write_vector_reg_W}), DATA_W'(0));
    check("t6:x0_data",    data_bus_W, 128'h5A5A);
    drive(1'b0, 6'h00, 128'h0, 1'b0, 6'h00, 128'h0);
    for (int k = 0; k < 4; k++) step("t6_drain");
    check("t6:drained", DATA_W'(fifo_count), DATA_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
